i_mem_wrap_gen2: RTL and testbench

- Parametrised next-generation instruction-memory wrapper for the gpc core tile.
- Serves the core fetch port (Q100H request, Q101H data) and the fabric/ring F2C port.
- Over the previous wrapper it adds:
  - ring byte-enable writes,
  - a ready/valid ring response path buffered by a response FIFO,
  - a fetch-output hold register with a reset NOP,
  - a configurable memory depth and region.

---
 rtl/lotr_pkg.sv | 18 +
 rtl/i_mem_be_dp.sv | 36 +++
 rtl/i_mem_wrap_gen2.sv | 140 ++++++++++++++
 tb/tb_i_mem_wrap_gen2.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lotr_pkg.sv
// Shared types and constants for the gpc tile instruction memory.
// Holds the ring opcode, the address region decode and fixed data words.
package lotr_pkg;

   typedef enum logic {
      RD = 1'b0,
      WR = 1'b1
   } t_opcode;

   localparam int MSB_REGION = 31;
   localparam int LSB_REGION = 16;

   localparam logic [MSB_REGION-LSB_REGION:0] I_MEM_REGION = '0;

   localparam logic [31:0] NOP_INST      = 32'h0000_0013;
   localparam logic [31:0] IMEM_LOCK_KEY = 32'h4C4F_434B;

endpackage

// File: rtl/i_mem_be_dp.sv
// True dual-port RAM, one clock, registered read outputs, read-before-write.
// Ports: i_clk; port a read-only (i_a_en, i_a_addr, o_a_data);
// port b (i_b_re, i_b_we[3:0] byte enables, i_b_addr, i_b_wdata, o_b_data).
module i_mem_be_dp #(
   parameter int DEPTH = 1024,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          i_clk,
   input  logic          i_a_en,
   input  logic [AW-1:0] i_a_addr,
   output logic [31:0]   o_a_data,
   input  logic          i_b_re,
   input  logic [3:0]    i_b_we,
   input  logic [AW-1:0] i_b_addr,
   input  logic [31:0]   i_b_wdata,
   output logic [31:0]   o_b_data
);

   logic [31:0] r_mem [DEPTH];
   logic [31:0] r_a_data;
   logic [31:0] r_b_data;

   // Reads sample the array before this edge's write lands.
   always_ff @(posedge i_clk) begin
      if (i_a_en) r_a_data <= r_mem[i_a_addr];
      if (i_b_re) r_b_data <= r_mem[i_b_addr];
      for (int i = 0; i < 4; i++) begin
         if (i_b_we[i])
            r_mem[i_b_addr][8*i +: 8] <= i_b_wdata[8*i +: 8];
      end
   end

   assign o_a_data = r_a_data;
   assign o_b_data = r_b_data;

endmodule

// File: rtl/i_mem_wrap_gen2.sv
// Instruction memory wrapper: core fetch port plus ring F2C port with byte
// enables and an in-order read-response FIFO.
// Ports: QClk, RstQnnnH; fetch PcQ100H/RdEnableQ100H -> InstFetchQ101H;
// ring request F2C_Req*Q503H with F2C_ReqReadyQ503H; ring response
// F2C_RspIMemValidQ504H/F2C_I_MemRspDataQ504H with F2C_RspReadyQ504H.
// Optional macro LOTR_IMEM_WR_PROTECT_EN adds a sticky write lock and the
// ImemLockedQ504H output.
import lotr_pkg::*;

module i_mem_wrap_gen2 #(
   parameter int I_MEM_DEPTH_WORDS = 1024,
   parameter int RSP_FIFO_DEPTH    = 4,
   parameter logic [MSB_REGION-LSB_REGION:0] REGION_ID = I_MEM_REGION,
   parameter logic [31:0] NOP_INST = lotr_pkg::NOP_INST
) (
   input  logic        QClk,
   input  logic        RstQnnnH,
   input  logic [31:0] PcQ100H,
   input  logic        RdEnableQ100H,
   output logic [31:0] InstFetchQ101H,
   input  logic        F2C_ReqValidQ503H,
   input  t_opcode     F2C_ReqOpcodeQ503H,
   input  logic [31:0] F2C_ReqAddressQ503H,
   input  logic [31:0] F2C_ReqDataQ503H,
   input  logic [3:0]  F2C_ReqByteEnQ503H,
   output logic        F2C_ReqReadyQ503H,
   output logic        F2C_RspIMemValidQ504H,
   output logic [31:0] F2C_I_MemRspDataQ504H,
   input  logic        F2C_RspReadyQ504H
`ifdef LOTR_IMEM_WR_PROTECT_EN
   ,
   output logic        ImemLockedQ504H
`endif
);

   localparam int AW = $clog2(I_MEM_DEPTH_WORDS);
   localparam int FW = $clog2(RSP_FIFO_DEPTH);

   logic [AW-1:0] w_idx;
   logic          w_hit;
   logic          w_fire;
   logic          w_rd;
   logic          w_wr_hit;
   logic          w_wr_ok;
   logic [31:0]   w_a_data;
   logic [31:0]   w_b_data;
   logic          w_valid;
   logic          w_pop;
   logic          w_pop_fifo;
   logic          w_push;
   logic [FW:0]   w_occ;
   logic [31:0]   w_rsp_data;
   logic          w_unused;

   logic [31:0]   r_fifo [RSP_FIFO_DEPTH];
   logic [FW-1:0] r_wptr;
   logic [FW-1:0] r_rptr;
   logic [FW:0]   r_cnt;
   logic          r_inflight;
   logic          r_fetch_sel;

   assign w_idx  = F2C_ReqAddressQ503H[AW+1:2];
   assign w_hit  = F2C_ReqAddressQ503H[MSB_REGION:LSB_REGION] == REGION_ID;
   assign w_fire = F2C_ReqValidQ503H & F2C_ReqReadyQ503H;
   assign w_rd   = w_fire & w_hit & (F2C_ReqOpcodeQ503H == RD);
   assign w_wr_hit = w_fire & w_hit & (F2C_ReqOpcodeQ503H == WR);

`ifdef LOTR_IMEM_WR_PROTECT_EN
   logic r_locked;

   always_ff @(posedge QClk) begin
      if (RstQnnnH)
         r_locked <= 1'b0;
      else if (w_wr_ok && F2C_ReqByteEnQ503H == 4'hF &&
               w_idx == AW'(I_MEM_DEPTH_WORDS - 1) &&
               F2C_ReqDataQ503H == IMEM_LOCK_KEY)
         r_locked <= 1'b1;
   end

   assign w_wr_ok = w_wr_hit & ~r_locked;
   assign ImemLockedQ504H = r_locked;
`else
   assign w_wr_ok = w_wr_hit;
`endif

   i_mem_be_dp #(
      .DEPTH (I_MEM_DEPTH_WORDS),
      .AW    (AW)
   ) u_mem (
      .i_clk     (QClk),
      .i_a_en    (RdEnableQ100H),
      .i_a_addr  (PcQ100H[AW+1:2]),
      .o_a_data  (w_a_data),
      .i_b_re    (w_rd),
      .i_b_we    (w_wr_ok ? F2C_ReqByteEnQ503H : 4'h0),
      .i_b_addr  (w_idx),
      .i_b_wdata (F2C_ReqDataQ503H),
      .o_b_data  (w_b_data)
   );

   // Outstanding reads = queued entries plus the one still in the SRAM.
   assign w_occ = r_cnt + (FW+1)'(r_inflight);
   assign F2C_ReqReadyQ503H =
      ~RstQnnnH & (w_occ < (FW+1)'(RSP_FIFO_DEPTH));

   // An empty FIFO lets the SRAM read data bypass straight to the output.
   assign w_valid    = ((r_cnt != '0) | r_inflight) & ~RstQnnnH;
   assign w_rsp_data = (r_cnt != '0) ? r_fifo[r_rptr] : w_b_data;
   assign w_pop      = w_valid & F2C_RspReadyQ504H;
   assign w_pop_fifo = w_pop & (r_cnt != '0);
   assign w_push     = r_inflight & ~((r_cnt == '0) & w_pop);

   assign F2C_RspIMemValidQ504H = w_valid;
   assign F2C_I_MemRspDataQ504H = w_valid ? w_rsp_data : 32'h0;

   always_ff @(posedge QClk) begin
      if (RstQnnnH) begin
         r_wptr      <= '0;
         r_rptr      <= '0;
         r_cnt       <= '0;
         r_inflight  <= 1'b0;
         r_fetch_sel <= 1'b0;
      end else begin
         r_inflight <= w_rd;
         if (RdEnableQ100H) r_fetch_sel <= 1'b1;
         if (w_push) begin
            r_fifo[r_wptr] <= w_b_data;
            r_wptr         <= r_wptr + 1'b1;
         end
         if (w_pop_fifo) r_rptr <= r_rptr + 1'b1;
         r_cnt <= r_cnt + (FW+1)'(w_push) - (FW+1)'(w_pop_fifo);
      end
   end

   // The SRAM read register holds when fetch is idle; NOP until first fetch.
   assign InstFetchQ101H = r_fetch_sel ? w_a_data : NOP_INST;

   assign w_unused = ^{PcQ100H, F2C_ReqAddressQ503H};

endmodule

// File: tb/tb_i_mem_wrap_gen2.sv
// Self-checking bench for i_mem_wrap_gen2: directed scenarios plus random
// traffic compared every cycle against a queue/array reference model.
module tb_i_mem_wrap_gen2;
   import lotr_pkg::*;

   localparam int DEPTH = 1024;
   localparam int FD    = 4;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [31:0] pc;
   logic        fen;
   logic [31:0] fetch;
   logic        rv;
   t_opcode     op;
   logic [31:0] ad;
   logic [31:0] dt;
   logic [3:0]  be;
   logic        rdy;
   logic        vld;
   logic [31:0] rdata;
   logic        rr;
`ifdef LOTR_IMEM_WR_PROTECT_EN
   logic        locked;
`endif

   i_mem_wrap_gen2 dut (
      .QClk                  (clk),
      .RstQnnnH              (rst),
      .PcQ100H               (pc),
      .RdEnableQ100H         (fen),
      .InstFetchQ101H        (fetch),
      .F2C_ReqValidQ503H     (rv),
      .F2C_ReqOpcodeQ503H    (op),
      .F2C_ReqAddressQ503H   (ad),
      .F2C_ReqDataQ503H      (dt),
      .F2C_ReqByteEnQ503H    (be),
      .F2C_ReqReadyQ503H     (rdy),
      .F2C_RspIMemValidQ504H (vld),
      .F2C_I_MemRspDataQ504H (rdata),
      .F2C_RspReadyQ504H     (rr)
`ifdef LOTR_IMEM_WR_PROTECT_EN
      ,
      .ImemLockedQ504H       (locked)
`endif
   );

   int          n_tests = 0;
   int          n_fail  = 0;
   bit          chk_on  = 1'b0;

   // Reference model: word array, fetch output, queue of owed responses.
   logic [31:0] m_mem [DEPTH];
   logic [31:0] m_fetch;
   logic [31:0] m_q [$];
   bit          m_lock;
   bit          m_acc;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp,
                  $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_on) begin
         if (rst) begin
            chk("valid_in_reset", 32'(vld), 32'h0);
         end else begin
            chk("fetch", fetch, m_fetch);
            chk("rsp_valid", 32'(vld), 32'(m_q.size() > 0));
            chk("rsp_data", rdata, m_q.size() > 0 ? m_q[0] : 32'h0);
            chk("req_ready", 32'(rdy), 32'(m_q.size() < FD));
`ifdef LOTR_IMEM_WR_PROTECT_EN
            chk("locked", 32'(locked), 32'(m_lock));
`endif
         end
      end
   end

   task automatic model(input logic i_rst, input logic i_fen,
                        input logic [31:0] i_pc, input logic i_rv,
                        input t_opcode i_op, input logic [31:0] i_ad,
                        input logic [31:0] i_dt, input logic [3:0] i_be,
                        input logic i_rr);
      logic [31:0] nf;
      bit          can;
      m_acc = 1'b0;
      if (i_rst) begin
         m_q.delete();
         m_fetch = 32'h0000_0013;
         m_lock  = 1'b0;
      end else begin
         can = m_q.size() < FD;
         nf  = i_fen ? m_mem[i_pc[11:2]] : m_fetch;
         if (m_q.size() > 0 && i_rr) void'(m_q.pop_front());
         if (i_rv && can) begin
            m_acc = 1'b1;
            if (i_ad[31:16] == 16'h0) begin
               if (i_op == WR) begin
                  if (!m_lock) begin
                     for (int b = 0; b < 4; b++)
                        if (i_be[b])
                           m_mem[i_ad[11:2]][8*b +: 8] = i_dt[8*b +: 8];
                  end
`ifdef LOTR_IMEM_WR_PROTECT_EN
                  if (i_be == 4'hF && i_ad[11:2] == 10'h3FF &&
                      i_dt == 32'h4C4F_434B)
                     m_lock = 1'b1;
`endif
               end else begin
                  m_q.push_back(m_mem[i_ad[11:2]]);
               end
            end
         end
         m_fetch = nf;
      end
   endtask

   // One clock: drive after the edge, model just past the negedge check.
   task automatic step(input logic i_rst, input logic i_fen,
                       input logic [31:0] i_pc, input logic i_rv,
                       input t_opcode i_op, input logic [31:0] i_ad,
                       input logic [31:0] i_dt, input logic [3:0] i_be,
                       input logic i_rr);
      rst = i_rst; fen = i_fen; pc = i_pc; rv = i_rv;
      op = i_op; ad = i_ad; dt = i_dt; be = i_be; rr = i_rr;
      @(negedge clk);
      #1;
      model(i_rst, i_fen, i_pc, i_rv, i_op, i_ad, i_dt, i_be, i_rr);
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] b);
      step(1'b0, 1'b0, 32'h0, 1'b1, WR, a, d, b, 1'b1);
   endtask

   task automatic rd(input logic [31:0] a, input logic r);
      step(1'b0, 1'b0, 32'h0, 1'b1, RD, a, 32'h0, 4'h0, r);
   endtask

   task automatic idle(input int n, input logic r);
      for (int i = 0; i < n; i++)
         step(1'b0, 1'b0, 32'h0, 1'b0, RD, 32'h0, 32'h0, 4'h0, r);
   endtask

   initial begin
      int acc;
      rst = 1'b1; fen = 1'b0; pc = '0; rv = 1'b0; op = RD;
      ad = '0; dt = '0; be = '0; rr = 1'b0;
      m_fetch = '0; m_lock = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_on = 1'b1;
      step(1'b1, 1'b0, 32'h0, 1'b0, RD, 32'h0, 32'h0, 4'h0, 1'b0);
      rst = 1'b0;
      #1;
      chk("reset_fetch_nop", fetch, 32'h0000_0013);
      chk("reset_valid", 32'(vld), 32'h0);
      chk("reset_ready", 32'(rdy), 32'h1);
      chk("reset_data", rdata, 32'h0);

      // Load a known image; word 0x80/4 stays zero.
      for (int i = 0; i < DEPTH; i++)
         wr(32'(i * 4), (i == 32) ? 32'h0 : $urandom, 4'hF);

      wr(32'h40, 32'hDEAD_BEEF, 4'hF);
      wr(32'h40, 32'h0000_5500, 4'h2);
      step(1'b0, 1'b1, 32'h40, 1'b0, RD, 32'h0, 32'h0, 4'h0, 1'b1);
      chk("be_merge_fetch", fetch, 32'hDEAD_55EF);
      for (int i = 0; i < 3; i++) begin
         idle(1, 1'b1);
         chk("fetch_hold", fetch, 32'hDEAD_55EF);
      end

      for (int i = 0; i < 6; i++)
         wr(32'h100 + 32'(i * 4), 32'hA000_0000 + 32'(i), 4'hF);
      acc = 0;
      for (int i = 0; i < 6; i++) begin
         rd(32'h100 + 32'(i * 4), 1'b0);
         if (m_acc) acc++;
      end
      chk("rd_accepted", 32'(acc), 32'd4);
      chk("ready_full", 32'(rdy), 32'h0);
      chk("head_data", rdata, 32'hA000_0000);
      idle(2, 1'b0);
      idle(6, 1'b1);
      chk("ready_back", 32'(rdy), 32'h1);
      chk("drained", 32'(vld), 32'h0);

      step(1'b0, 1'b1, 32'h80, 1'b1, WR, 32'h80, 32'h1234_5678, 4'hF, 1'b1);
      chk("rbw_old", fetch, 32'h0);
      step(1'b0, 1'b1, 32'h80, 1'b0, RD, 32'h0, 32'h0, 4'h0, 1'b1);
      chk("rbw_new", fetch, 32'h1234_5678);

      rd(32'h0001_0040, 1'b1);
      wr(32'h0002_0040, 32'h0, 4'hF);
      for (int i = 0; i < 5; i++) begin
         idle(1, 1'b1);
         chk("miss_no_rsp", 32'(vld), 32'h0);
      end
      step(1'b0, 1'b1, 32'h40, 1'b0, RD, 32'h0, 32'h0, 4'h0, 1'b1);
      chk("miss_no_write", fetch, 32'hDEAD_55EF);

      rd(32'h40, 1'b0);
      step(1'b1, 1'b0, 32'h0, 1'b0, RD, 32'h0, 32'h0, 4'h0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         idle(1, 1'b1);
         chk("rst_drop_rd", 32'(vld), 32'h0);
      end

`ifdef LOTR_IMEM_WR_PROTECT_EN
      wr(32'hFFC, 32'h4C4F_434B, 4'hF);
      chk("lock_set", 32'(locked), 32'h1);
      wr(32'h40, 32'h1, 4'hF);
      rd(32'h40, 1'b0);
      chk("lock_protect", rdata, 32'hDEAD_55EF);
      idle(1, 1'b1);
`endif

      for (int i = 0; i < 3000; i++) begin
         logic [31:0] a;
         if ($urandom_range(0, 9) < 8)
            a = {16'h0, 4'h0, 10'($urandom_range(0, DEPTH - 1)),
                 2'($urandom)};
         else
            a = {16'($urandom_range(1, 65535)), 16'($urandom)};
         step($urandom_range(0, 199) == 0, 1'($urandom), $urandom,
              1'($urandom), t_opcode'($urandom_range(0, 1)), a,
              $urandom, 4'($urandom), 1'($urandom));
      end
      idle(8, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
